// File: rtl/io_register_bank.sv
// Processor-facing register bank with control, write-1-to-clear status and an optional interrupt.
// Define IO_REG_BANK_IRQ_EN to build the IRQ_EN register and the Irq logic.
module io_register_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CTRL = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [ADDR_WIDTH-1:0]          Sys_Addr,
  input  logic                           Sys_WrEn,
  input  logic                           Sys_RdEn,
  input  logic [DATA_WIDTH-1:0]          Sys_WrData,
  output logic [DATA_WIDTH-1:0]          Sys_RdData,
  output logic                           Sys_RdValid,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] IO_CtrlData,
  output logic [NUM_CTRL-1:0]            IO_CtrlStrobe,
  input  logic [DATA_WIDTH-1:0]          IO_StatusSet,
  output logic                           Irq
);

  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(NUM_CTRL);
`ifdef IO_REG_BANK_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] IRQ_EN_ADDR = ADDR_WIDTH'(NUM_CTRL + 1);
`endif

  logic [DATA_WIDTH-1:0] ctrlReg [NUM_CTRL];
  logic [DATA_WIDTH-1:0] statusReg;
  logic [NUM_CTRL-1:0]   ctrlWrSel_c;
  logic                  statusWr_c;
  logic [DATA_WIDTH-1:0] statusClr_c;
  logic [DATA_WIDTH-1:0] readMux_c;
`ifdef IO_REG_BANK_IRQ_EN
  logic [DATA_WIDTH-1:0] irqEnReg;
  logic                  irqEnWr_c;
`endif

  // Write address decode
  always_comb begin
    ctrlWrSel_c = '0;
    for (int unsigned k = 0; k < NUM_CTRL; k++) begin
      ctrlWrSel_c[k] = Sys_WrEn && (Sys_Addr == ADDR_WIDTH'(k));
    end
    statusWr_c  = Sys_WrEn && (Sys_Addr == STATUS_ADDR);
    statusClr_c = statusWr_c ? Sys_WrData : '0;
  end

`ifdef IO_REG_BANK_IRQ_EN
  assign irqEnWr_c = Sys_WrEn && (Sys_Addr == IRQ_EN_ADDR);
`endif

  // Read mux sees the flops before this cycle's write or set lands
  always_comb begin
    readMux_c = '0;
    for (int unsigned k = 0; k < NUM_CTRL; k++) begin
      if (Sys_Addr == ADDR_WIDTH'(k)) readMux_c = ctrlReg[k];
    end
    if (Sys_Addr == STATUS_ADDR) readMux_c = statusReg;
`ifdef IO_REG_BANK_IRQ_EN
    if (Sys_Addr == IRQ_EN_ADDR) readMux_c = irqEnReg;
`endif
  end

  // Control registers and their write strobes
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_CTRL; k++) ctrlReg[k] <= RESET_VALUE;
      IO_CtrlStrobe <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CTRL; k++) begin
        if (ctrlWrSel_c[k]) ctrlReg[k] <= Sys_WrData;
      end
      IO_CtrlStrobe <= ctrlWrSel_c;
    end
  end

  for (genvar g = 0; g < int'(NUM_CTRL); g++) begin : gCtrlOut
    assign IO_CtrlData[g*DATA_WIDTH +: DATA_WIDTH] = ctrlReg[g];
  end

  // Status: set is OR-ed in after the clear so a coincident set wins
  always_ff @(posedge Clock) begin
    if (Reset) statusReg <= '0;
    else       statusReg <= (statusReg & ~statusClr_c) | IO_StatusSet;
  end

  // Registered read port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Sys_RdData  <= '0;
      Sys_RdValid <= 1'b0;
    end else begin
      Sys_RdValid <= Sys_RdEn;
      if (Sys_RdEn) Sys_RdData <= readMux_c;
    end
  end

`ifdef IO_REG_BANK_IRQ_EN
  // Interrupt enable and registered interrupt request
  always_ff @(posedge Clock) begin
    if (Reset) begin
      irqEnReg <= '0;
      Irq      <= 1'b0;
    end else begin
      if (irqEnWr_c) irqEnReg <= Sys_WrData;
      Irq <= |(statusReg & irqEnReg);
    end
  end
`else
  assign Irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_register_bank.sv
// Scoreboard bench for io_register_bank; expected read data is queued at the strobe and
// retired by a monitor when Sys_RdValid appears.
module tb_io_register_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 4;
  localparam logic [DW-1:0] RV = 32'hA5A5_0000;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [AW-1:0]     Sys_Addr;
  logic              Sys_WrEn;
  logic              Sys_RdEn;
  logic [DW-1:0]     Sys_WrData;
  logic [DW-1:0]     Sys_RdData;
  logic              Sys_RdValid;
  logic [NC*DW-1:0]  IO_CtrlData;
  logic [NC-1:0]     IO_CtrlStrobe;
  logic [DW-1:0]     IO_StatusSet;
  logic              Irq;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] expQ [$];
  logic [DW-1:0] monExp;
  logic [DW-1:0] ctrlModel [NC];
  logic [DW-1:0] statusModel;
  logic [DW-1:0] irqEnModel;

  io_register_bank #(
    .DATA_WIDTH(DW), .NUM_CTRL(NC), .ADDR_WIDTH(AW), .RESET_VALUE(RV)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Sys_Addr(Sys_Addr), .Sys_WrEn(Sys_WrEn),
    .Sys_RdEn(Sys_RdEn), .Sys_WrData(Sys_WrData), .Sys_RdData(Sys_RdData),
    .Sys_RdValid(Sys_RdValid), .IO_CtrlData(IO_CtrlData), .IO_CtrlStrobe(IO_CtrlStrobe),
    .IO_StatusSet(IO_StatusSet), .Irq(Irq)
  );

  always #5 Clock = ~Clock;

  // Read monitor: retires one queued expectation per valid beat
  always @(negedge Clock) begin
    if (Sys_RdValid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: Sys_RdValid=1 data=%h with no read outstanding", Sys_RdData);
      end else begin
        monExp = expQ.pop_front();
        if (Sys_RdData !== monExp) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", Sys_RdData, monExp);
        end
      end
    end
  end

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
    if (int'(a) < int'(NC)) return ctrlModel[int'(a)];
    if (int'(a) == int'(NC)) return statusModel;
`ifdef IO_REG_BANK_IRQ_EN
    if (int'(a) == int'(NC) + 1) return irqEnModel;
`endif
    return '0;
  endfunction

  function automatic logic [NC*DW-1:0] flatModel();
    logic [NC*DW-1:0] f;
    for (int k = 0; k < int'(NC); k++) f[k*DW +: DW] = ctrlModel[k];
    return f;
  endfunction

  task automatic idle();
    Sys_WrEn = 1'b0;
    Sys_RdEn = 1'b0;
    IO_StatusSet = '0;
  endtask

  task automatic drain();
    #1;
    for (int i = 0; i < 4 && expQ.size() != 0; i++) begin
      @(negedge Clock);
      #1;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL rd_timeout: %0d reads outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // One bus cycle; returns just after the edge that consumed it
  task automatic cycle(input logic [AW-1:0] a, input logic rd, input logic wr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] set);
    logic [DW-1:0] clr;
    if (rd) expQ.push_back(modelRead(a));
    clr = '0;
    if (wr) begin
      if (int'(a) < int'(NC)) ctrlModel[int'(a)] = wd;
      else if (int'(a) == int'(NC)) clr = wd;
`ifdef IO_REG_BANK_IRQ_EN
      else if (int'(a) == int'(NC) + 1) irqEnModel = wd;
`endif
    end
    statusModel = (statusModel & ~clr) | set;
    Sys_Addr = a; Sys_RdEn = rd; Sys_WrEn = wr; Sys_WrData = wd; IO_StatusSet = set;
    @(negedge Clock);
    idle();
    if (rd) drain();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Sys_WrEn = 1'b1; Sys_Addr = '0; Sys_WrData = '1;
    Sys_RdEn = 1'b1; IO_StatusSet = '1;
    @(negedge Clock);
    @(negedge Clock);
    for (int k = 0; k < int'(NC); k++) begin
      checks++;
      if (IO_CtrlData[k*DW +: DW] !== RV) begin
        errors++;
        $display("FAIL reset_ctrl%0d: got %h expected %h", k, IO_CtrlData[k*DW +: DW], RV);
      end
    end
    checks++;
    if (Sys_RdValid !== 1'b0 || Sys_RdData !== '0 || IO_CtrlStrobe !== '0 || Irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h strobe=%b irq=%b expected 0", Sys_RdValid,
               Sys_RdData, IO_CtrlStrobe, Irq);
    end
    Reset = 1'b0;
    idle();
    for (int k = 0; k < int'(NC); k++) ctrlModel[k] = RV;
    statusModel = '0;
    irqEnModel = '0;
    @(negedge Clock);
    checks++;
    if (Sys_RdValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdvalid: got %b expected 0", Sys_RdValid);
    end
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
    cycle(AW'(0), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_ctrl_write();
    logic [DW-1:0] d;
    cycle(AW'(2), 1'b0, 1'b1, 32'h1234_5678, '0);
    checks++;
    if (IO_CtrlData[95:64] !== 32'h1234_5678 || IO_CtrlStrobe !== 4'b0100) begin
      errors++;
      $display("FAIL ctrl_write: data=%h strobe=%b expected 12345678 0100", IO_CtrlData[95:64],
               IO_CtrlStrobe);
    end
    @(negedge Clock);
    checks++;
    if (IO_CtrlStrobe !== 4'b0000) begin
      errors++;
      $display("FAIL ctrl_strobe_width: got %b expected 0000", IO_CtrlStrobe);
    end
    cycle(AW'(2), 1'b1, 1'b0, '0, '0);
    for (int k = 0; k < int'(NC); k++) begin
      d = $urandom;
      cycle(AW'(k), 1'b0, 1'b1, d, '0);
      checks++;
      if (IO_CtrlData !== flatModel()) begin
        errors++;
        $display("FAIL ctrl_flat%0d: got %h expected %h", k, IO_CtrlData, flatModel());
      end
      cycle(AW'(k), 1'b1, 1'b0, '0, '0);
    end
  endtask

  task automatic test_status();
    cycle(AW'(0), 1'b0, 1'b0, '0, 32'h0000_0011);
    cycle(AW'(NC), 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001);
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
    cycle(AW'(NC), 1'b0, 1'b1, 32'h0000_0011, '0);
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
    // read concurrent with a set returns the pre-set value
    cycle(AW'(NC), 1'b1, 1'b0, '0, 32'h0000_0100);
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
    cycle(AW'(NC), 1'b0, 1'b1, 32'h0000_0100, '0);
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_irq();
`ifdef IO_REG_BANK_IRQ_EN
    cycle(AW'(NC + 1), 1'b0, 1'b1, 32'h0000_0010, '0);
    cycle(AW'(NC + 1), 1'b1, 1'b0, '0, '0);
    cycle(AW'(0), 1'b0, 1'b0, '0, 32'h0000_0010);
    checks++;
    if (Irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", Irq); end
    @(negedge Clock);
    checks++;
    if (Irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", Irq); end
    cycle(AW'(NC), 1'b0, 1'b1, 32'h0000_0010, '0);
    checks++;
    if (Irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", Irq); end
    @(negedge Clock);
    checks++;
    if (Irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", Irq); end
    cycle(AW'(0), 1'b0, 1'b0, '0, 32'h0000_0001);
    @(negedge Clock);
    checks++;
    if (Irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", Irq); end
    cycle(AW'(NC), 1'b0, 1'b1, 32'h0000_0001, '0);
`else
    cycle(AW'(NC + 1), 1'b0, 1'b1, '1, '0);
    cycle(AW'(NC + 1), 1'b1, 1'b0, '0, '0);
    cycle(AW'(0), 1'b0, 1'b0, '0, 32'h0000_0010);
    @(negedge Clock);
    checks++;
    if (Irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b expected 0", Irq); end
    cycle(AW'(NC), 1'b0, 1'b1, 32'h0000_0010, '0);
`endif
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_rw_same_cycle();
    cycle(AW'(0), 1'b0, 1'b1, 32'h0000_0000, '0);
    cycle(AW'(0), 1'b1, 1'b1, 32'hFFFF_FFFF, '0);
    cycle(AW'(0), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_unmapped();
    cycle(AW'(15), 1'b0, 1'b1, 32'hDEAD_BEEF, '0);
    checks++;
    if (IO_CtrlData !== flatModel() || IO_CtrlStrobe !== '0) begin
      errors++;
      $display("FAIL unmapped_write: data=%h strobe=%b expected %h 0", IO_CtrlData,
               IO_CtrlStrobe, flatModel());
    end
    cycle(AW'(15), 1'b1, 1'b0, '0, '0);
    cycle(AW'(NC), 1'b1, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] last;
    for (int a = 0; a < int'(NC) + 2; a++) begin
      expQ.push_back(modelRead(AW'(a)));
      Sys_Addr = AW'(a);
      Sys_RdEn = 1'b1;
      @(negedge Clock);
    end
    idle();
    drain();
    last = modelRead(AW'(NC + 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (Sys_RdData !== last || Sys_RdValid !== 1'b0) begin
        errors++;
        $display("FAIL rd_hold: data=%h valid=%b expected %h 0", Sys_RdData, Sys_RdValid, last);
      end
    end
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    Sys_Addr = '0;
    Sys_WrData = '0;
    @(negedge Clock);
    test_reset();
    test_ctrl_write();
    test_status();
    test_irq();
    test_rw_same_cycle();
    test_unmapped();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/io_register_bank.md
IO_REGISTER_BANK -- requirements
Module: io_register_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the width of every register and data port.
REQ-002 The block SHALL have parameter NUM_CTRL, default 4, legal range 1..14, which sets the number of control registers.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, which sets the width of the register address; 2**ADDR_WIDTH SHALL be at least NUM_CTRL+2.
REQ-004 The block SHALL have parameter RESET_VALUE [DATA_WIDTH-1:0], default all-zero, which is the reset value of every control register.
REQ-005 Clock  in  1  system clock; all state updates on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Sys_Addr  in  ADDR_WIDTH  register address from the processor.
REQ-008 Sys_WrEn  in  1  one-cycle processor write strobe.
REQ-009 Sys_RdEn  in  1  one-cycle processor read strobe.
REQ-010 Sys_WrData  in  DATA_WIDTH  processor write data.
REQ-011 Sys_RdData  out  DATA_WIDTH  registered read data.
REQ-012 Sys_RdValid  out  1  high for one cycle when Sys_RdData is valid.
REQ-013 IO_CtrlData  out  NUM_CTRL*DATA_WIDTH  control register contents, with register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 IO_CtrlStrobe  out  NUM_CTRL  one-cycle pulse on bit k when control register k is written.
REQ-015 IO_StatusSet  in  DATA_WIDTH  per-bit status set pulses from the I/O logic.
REQ-016 Irq  out  1  registered interrupt request.

Function
REQ-017 The register map SHALL be: addresses 0..NUM_CTRL-1 are the control registers (read/write); address NUM_CTRL is STATUS (read, write-1-to-clear); address NUM_CTRL+1 is IRQ_EN (read/write); all other addresses are unmapped.
REQ-018 A control-register write SHALL load Sys_WrData on the same clock edge and SHALL assert IO_CtrlStrobe[k] in the following cycle for exactly one cycle.
REQ-019 IO_CtrlData SHALL reflect the control register flops directly, with no extra delay.
REQ-020 Each STATUS bit SHALL be set by an IO_StatusSet bit held high in any cycle, and SHALL be cleared by a STATUS write carrying a 1 in that bit.
REQ-021 When a STATUS set and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win and the bit SHALL read 1 afterwards.
REQ-022 Read latency SHALL be one cycle: a read strobe at edge N SHALL produce Sys_RdData and Sys_RdValid=1 after edge N+1.
REQ-023 Sys_RdData SHALL hold its value until the next read strobe.
REQ-024 A read and a write to the same address in the same cycle SHALL return the pre-write value.
REQ-025 A STATUS read in the same cycle as a set SHALL return the pre-set value.
REQ-026 Writes to unmapped addresses SHALL be ignored, and reads of unmapped addresses SHALL return 0 with Sys_RdValid=1.
REQ-027 Irq SHALL be registered as the OR-reduction of (STATUS & IRQ_EN), and SHALL update one cycle after a change in STATUS or IRQ_EN.

Reset
REQ-028 Reset SHALL force: every control register to RESET_VALUE; STATUS to 0; IRQ_EN to 0; IO_CtrlStrobe to 0; Sys_RdData to 0; Sys_RdValid to 0; Irq to 0.
REQ-029 Reset SHALL take priority over any concurrent write, read or status set, and a read in progress when Reset asserts SHALL NOT produce Sys_RdValid.

Configuration
REQ-030 With macro IO_REG_BANK_IRQ_EN defined, the IRQ_EN register and the Irq logic SHALL be present as specified above.
REQ-031 Without IO_REG_BANK_IRQ_EN, address NUM_CTRL+1 SHALL behave as unmapped, and Irq SHALL be tied to 0.

Verification
REQ-032 Reset with RESET_VALUE=32'hA5A5_0000 -> every IO_CtrlData slice reads 32'hA5A5_0000, STATUS reads 0, Irq=0.
REQ-033 Write 32'h1234_5678 to address 2 -> IO_CtrlData[95:64]=32'h1234_5678 after the edge; IO_CtrlStrobe=4'b0100 for one cycle after that; a read of address 2 returns the value with 1-cycle latency.
REQ-034 Pulse IO_StatusSet=32'h0000_0011, then write STATUS=32'h0000_0001 concurrent with IO_StatusSet=32'h0000_0001 -> STATUS reads 32'h0000_0011 (set wins); a later write of 32'h11 with no set -> STATUS reads 0.
REQ-035 (IRQ_EN defined) IRQ_EN=32'h10, pulse IO_StatusSet bit 4 -> Irq=1 one cycle after STATUS updates; clear bit 4 -> Irq=0 one cycle later; without the macro, Irq stays 0 and address 5 reads 0.
REQ-036 Read and write of address 0 in the same cycle (old value 32'h0, new 32'hFFFF_FFFF) -> Sys_RdData=0; next read returns 32'hFFFF_FFFF.
REQ-037 Write to address 15 followed by a read of address 15 -> no register changes, Sys_RdData=0, Sys_RdValid=1.
